execute_muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide sequencer attached to the Execute stage beside the ALU.
- Accepts one M-extension operation while the instruction sits in EX and stalls the front of the pipeline during iteration.
- Presents a registered 32-bit result for one cycle, on the cycle the pipeline is released.
- Flush and stall interact with the hazard unit; operands come from the already-forwarded ALU inputs.

---
 rtl/execute_muldiv_unit.sv | 121 ++++++++++++
 tb/tb_execute_muldiv_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv_unit.sv
// execute_muldiv_unit: iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
//   clk, reset (sync, active-low)
//   start, op[2:0] (funct3), operand_a, operand_b, flush      -> inputs
//   busy (not IDLE), stall (freeze IF/ID/EX), result_valid (1-cycle pulse), result -> outputs
module execute_muldiv_unit #(
   parameter int XLEN         = 32,
   parameter bit FAST_SPECIAL = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   input  logic            flush,
   output logic            busy,
   output logic            stall,
   output logic            result_valid,
   output logic [XLEN-1:0] result
);
   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};
   typedef enum logic [2:0] {IDLE, MUL, DIV, FIN, DONE} state_t;
   state_t state, state_n;
   logic [2:0]        op_q;
   logic              neg, neg_r;
   logic [XLEN-1:0]   mag;
   logic [2*XLEN-1:0] acc;
   logic [CW-1:0]     count;
   logic              sa, sb, bz, ovf, special;
   logic [XLEN-1:0]   abs_a, abs_b, spec_res, fin_res, quo, rem;
   logic [XLEN:0]     sum, shifted, diff;
   logic              ge;
   logic [2*XLEN-1:0] mul_next, div_next, prod;

   // operand decode: MULH/DIV/REM are signed on both sides, MULHSU on a only
   always_comb begin
      sa       = (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd6) && operand_a[XLEN-1];
      sb       = (op == 3'd1 || op == 3'd4 || op == 3'd6) && operand_b[XLEN-1];
      abs_a    = sa ? -operand_a : operand_a;
      abs_b    = sb ? -operand_b : operand_b;
      bz       = operand_b == '0;
      ovf      = !op[0] && operand_a == MIN_VAL && operand_b == '1;
      special  = FAST_SPECIAL && op[2] && (bz || ovf);
      spec_res = bz ? (op[1] ? operand_a : '1) : (op[1] ? '0 : MIN_VAL);
   end

   // acc holds {hi, multiplier} for MUL and {remainder, dividend/quotient} for DIV
   always_comb begin
      sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag} : '0);
      mul_next = {sum, acc[XLEN-1:1]};
      shifted  = acc[2*XLEN-1:XLEN-1];
      ge       = shifted >= {1'b0, mag};
      diff     = shifted - {1'b0, mag};
      div_next = {ge ? diff[XLEN-1:0] : shifted[XLEN-1:0], acc[XLEN-2:0], ge};
      prod     = neg ? -acc : acc;
      quo      = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem      = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      fin_res  = op_q[2] ? (op_q[1] ? rem : quo)
                         : (op_q == 3'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = special ? DONE : (op[2] ? DIV : MUL);
         MUL,
         DIV:     if (count == '0) state_n = FIN;
         FIN:     state_n = DONE;
         default: state_n = IDLE;
      endcase
      if (flush) state_n = IDLE;
   end

   always_comb begin
      busy         = state != IDLE;
      result_valid = state == DONE;
      stall        = (state == IDLE && start && !flush && !special) ||
                     state == MUL || state == DIV || state == FIN;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         op_q   <= '0;
         neg    <= 1'b0;
         neg_r  <= 1'b0;
         mag    <= '0;
         acc    <= '0;
         count  <= '0;
         result <= '0;
      end else begin
         case (state)
            IDLE: if (start && !flush) begin
               op_q  <= op;
               // divide-by-zero keeps an all-ones quotient, so no negation there
               neg   <= (sa ^ sb) && (!op[2] || !bz);
               neg_r <= sa;
               mag   <= op[2] ? abs_b : abs_a;
               acc   <= {{XLEN{1'b0}}, op[2] ? abs_a : abs_b};
               count <= CW'(XLEN - 1);
               if (special) result <= spec_res;
            end
            MUL: begin
               acc   <= mul_next;
               count <= count - 1'b1;
            end
            DIV: begin
               acc   <= div_next;
               count <= count - 1'b1;
            end
            FIN: if (!flush) result <= fin_res;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_execute_muldiv_unit.sv
// tb_execute_muldiv_unit: scoreboard bench for the RV32M multiply/divide sequencer.
module tb_execute_muldiv_unit;
   logic        clk = 0, reset = 0, start = 0, flush = 0;
   logic [2:0]  op = 0;
   logic [31:0] operand_a = 0, operand_b = 0;
   logic        busy, stall, result_valid;
   logic [31:0] result;
   logic [31:0] sb[$];
   int checks = 0, errors = 0;

   execute_muldiv_unit dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
      .busy(busy), .stall(stall), .result_valid(result_valid), .result(result)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   // Each task starts and ends 1 time unit after a rising edge.
   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input int lat, input string name);
      logic [31:0] e;
      bit seen = 0;
      sb.push_back(exp_r);
      op = o; operand_a = a; operand_b = b; start = 1;
      for (int cyc = 0; cyc <= 40 && !seen; cyc++) begin
         #1;
         if (result_valid) begin
            seen = 1;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL %s: unexpected result_valid, no pending result", name);
            end else begin
               e = sb.pop_front();
               if (result !== e || cyc != lat) begin
                  errors++;
                  $display("FAIL %s: result=%h at cycle %0d, expected %h at cycle %0d",
                           name, result, cyc, e, lat);
               end
            end
            checks++;
            if (stall !== 1'b0) begin
               errors++;
               $display("FAIL %s_stall_done: stall=%b, expected 0", name, stall);
            end
         end else begin
            checks++;
            if (stall !== (lat != 1)) begin
               errors++;
               $display("FAIL %s_stall: stall=%b in cycle %0d, expected %b", name, stall, cyc, lat != 1);
            end
         end
         next_cycle();
         // operands change during iteration and must be ignored
         operand_a = ~a; operand_b = ~b; op = ~o;
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL %s_timeout: no result_valid within 40 cycles, expected cycle %0d", name, lat);
      end
      start = 0;
      #1;
      checks++;
      if (busy !== 1'b0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL %s_no_restart: busy=%b stall=%b after DONE, expected 0 0", name, busy, stall);
      end
      next_cycle();
   endtask

   task automatic test_reset();
      reset = 0;
      repeat (3) next_cycle();
      checks++;
      if ({busy, stall, result_valid, result} !== 35'd0) begin
         errors++;
         $display("FAIL reset: busy=%b stall=%b valid=%b result=%h, expected all 0",
                  busy, stall, result_valid, result);
      end
      reset = 1;
      next_cycle();
   endtask

   task automatic test_mul();
      run_op(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul");
      run_op(3'd1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 34, "mulh");
      run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu");
      run_op(3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 34, "mulhsu");
      run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34, "mulh_min");
   endtask

   task automatic test_div();
      run_op(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, "div");
      run_op(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, "rem");
      run_op(3'd5, 32'd100, 32'd7, 32'd14, 34, "divu");
      run_op(3'd7, 32'd100, 32'd7, 32'd2, 34, "remu");
   endtask

   task automatic test_special();
      run_op(3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "divu_zero");
      run_op(3'd6, 32'd5, 32'd0, 32'd5, 1, "rem_zero");
      run_op(3'd4, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 1, "div_neg_zero");
      run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");
      run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, "rem_ovf");
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      logic [63:0] p;
      for (int i = 0; i < 4; i++) begin
         a = $urandom; b = $urandom | 32'd1;
         p = {32'd0, a} * {32'd0, b};
         run_op(3'd3, a, b, p[63:32], 34, "rand_mulhu");
         run_op(3'd5, a, b, a / b, 34, "rand_divu");
      end
   endtask

   task automatic test_flush();
      op = 3'd4; operand_a = 32'd1000; operand_b = 32'd3; start = 1;
      repeat (10) next_cycle();
      flush = 1;
      next_cycle();
      flush = 0; start = 0;
      #1;
      checks++;
      if (stall !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush: stall=%b busy=%b valid=%b, expected 0 0 0", stall, busy, result_valid);
      end
      next_cycle();
      run_op(3'd0, 32'd12345, 32'd678, 32'd8369910, 34, "mul_after_flush");
   endtask

   task automatic test_reset_mid();
      op = 3'd0; operand_a = 32'd9; operand_b = 32'd9; start = 1;
      repeat (5) next_cycle();
      reset = 0;
      next_cycle();
      start = 0;
      #1;
      checks++;
      if ({busy, stall, result_valid, result} !== 35'd0) begin
         errors++;
         $display("FAIL reset_mid: busy=%b stall=%b valid=%b result=%h, expected all 0",
                  busy, stall, result_valid, result);
      end
      reset = 1;
      next_cycle();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_idle: busy=%b, expected 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      run_op(3'd0, 32'd3, 32'd4, 32'd12, 34, "b2b_first");
      run_op(3'd7, 32'd17, 32'd5, 32'd2, 34, "b2b_second");
   endtask

   initial begin
      next_cycle();
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_random();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
